alu_seq_slice: RTL

Parametrised multi-cycle ALU, next generation of the 6-bit ripple ALU. One SLICE-bit ripple slice is reused over WIDTH/SLICE cycles to process WIDTH-bit operands, least significant slice first. Carry is registered between slices. Adds a valid/ready handshake on both sides, SLT, overflow/zero flags and result buffering. Sits between the RV datapath operand registers and writeback as a low-area ALU option.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_slice.sv | 46 ++++
 rtl/alu_seq_slice.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential slice ALU: opcode values, FSM encoding
// and opcode-class helpers used by both the slice and the sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

    // SUB/SLT add ~b + 1, so the "+1" enters as the slice-0 carry.
    function automatic logic init_carry(input logic [3:0] op, input logic cin);
        if (op == ALU_ADD) begin
            return cin;
        end
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ripple slice: logic ops or add with optional b inversion.
// Also exposes the carry into its MSB so the sequencer can form signed overflow.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic [SLICE-1:0] res_s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] sum;
    logic             carry;

    always_comb begin
        b_eff    = ((op == ALU_SUB) || (op == ALU_SLT)) ? ~b_s : b_s;
        sum      = '0;
        c_msb_in = 1'b0;
        carry    = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i] = a_s[i] ^ b_eff[i] ^ carry;
            if (i == SLICE - 1) begin
                c_msb_in = carry;
            end
            carry = (a_s[i] & b_eff[i]) | (a_s[i] & carry) | (b_eff[i] & carry);
        end
        cout = carry;
    end

    always_comb begin
        case (op)
            ALU_AND:                   res_s = a_s & b_s;
            ALU_OR:                    res_s = a_s | b_s;
            ALU_NOR:                   res_s = ~(a_s | b_s);
            ALU_ADD, ALU_SUB, ALU_SLT: res_s = sum;
            default:                   res_s = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_slice.sv
// Multi-cycle ALU: one alu_slice reused WIDTH/SLICE times, LS slice first,
// with registered inter-slice carry and valid/ready on both sides.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for in_valid; operands captured on accept
// RUN     | one slice per cycle, counter selects slice k
// DONE    | out_valid=1, outputs held until out_ready
module alu_seq_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r, res_r;
    logic [3:0]       op_r;
    logic             carry_r, cout_r, ovf_r;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      base;
    logic             accept;

    logic [SLICE-1:0] s_res;
    logic             s_cout, s_cmsb;

    assign base = 32'(cnt) * 32'(SLICE);

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a_s      (a_r[base +: SLICE]),
        .b_s      (b_r[base +: SLICE]),
        .cin      (carry_r),
        .op       (op_r),
        .res_s    (s_res),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= ALU_AND;
            carry_r <= 1'b0;
            cnt     <= '0;
            res_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= ALUOp;
            carry_r <= init_carry(ALUOp, CarryIn);
            cnt     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == ST_RUN) begin
            carry_r <= s_cout;
            if (cnt == LAST) begin
                cnt    <= '0;
                cout_r <= ((op_r == ALU_ADD) || (op_r == ALU_SUB)) && s_cout;
                ovf_r  <= is_arith(op_r) && (s_cmsb ^ s_cout);
                // SLT collapses to the sign of (a-b), corrected for overflow.
                if (op_r == ALU_SLT) begin
                    res_r <= WIDTH'(s_res[SLICE-1] ^ s_cmsb ^ s_cout);
                end else begin
                    res_r[base +: SLICE] <= s_res;
                end
            end else begin
                cnt                  <= cnt + 1'b1;
                res_r[base +: SLICE] <= s_res;
            end
        end
    end

    assign Result   = res_r;
    assign CarryOut = cout_r;
    assign Overflow = ovf_r;
    assign Zero     = (state == ST_DONE) && (res_r == '0);

endmodule
